// File: rtl/tap_controller.sv
// tap_controller
// IEEE 1149.1 TAP controller. TMS is decoded on the rising edge of TCK into
// the 16-state TAP state machine. The register control strobes are decoded
// from that state and re-registered on the falling edge, so each strobe is
// stable across the following rising edge where the data registers act on it.
//
// Ports
//   tck        : JTAG test clock, the only clock
//   trst       : asynchronous active-low test reset
//   tms        : test mode select, sampled on tck rising edge
//   state      : current TAP state (standard 1149.1 hex encoding)
//   tlr_n      : active-low test-logic reset, low while in Test-Logic-Reset
//   select     : 1 = IR path selected for the TDO mux, 0 = DR path
//   enable     : TDO driver enable, high in Shift-DR / Shift-IR
//   captureIR, shiftIR, updateIR : IR control levels
//   clockIR    : gated IR capture/shift clock
//   captureDR, shiftDR, updateDR : DR control levels
//   clockDR    : gated DR capture/shift clock
module tap_controller (
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output logic [3:0] state,
    output logic       tlr_n,
    output logic       select,
    output logic       enable,
    output logic       captureIR,
    output logic       shiftIR,
    output logic       updateIR,
    output logic       clockIR,
    output logic       captureDR,
    output logic       shiftDR,
    output logic       updateDR,
    output logic       clockDR
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    tap_state_e cur_state;
    tap_state_e next_state;

    logic dec_tlr_n;
    logic dec_select;
    logic dec_enable;
    logic dec_capture_ir;
    logic dec_shift_ir;
    logic dec_update_ir;
    logic dec_capture_dr;
    logic dec_shift_dr;
    logic dec_update_dr;
    logic dec_dr_en;
    logic dec_ir_en;

    logic dr_en;
    logic ir_en;

    // TAP state register, advanced by TMS on every rising edge of tck.
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            cur_state <= TLR;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state table plus the strobe decode that the falling-edge stage
    // registers.
    always_comb begin
        next_state     = cur_state;
        dec_tlr_n      = 1'b1;
        dec_select     = 1'b0;
        dec_enable     = 1'b0;
        dec_capture_ir = 1'b0;
        dec_shift_ir   = 1'b0;
        dec_update_ir  = 1'b0;
        dec_capture_dr = 1'b0;
        dec_shift_dr   = 1'b0;
        dec_update_dr  = 1'b0;
        dec_dr_en      = 1'b0;
        dec_ir_en      = 1'b0;

        case (cur_state)
            TLR:     next_state = tms ? TLR    : RTI;
            RTI:     next_state = tms ? SEL_DR : RTI;
            SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
            SH_DR:   next_state = tms ? EX1_DR : SH_DR;
            EX1_DR:  next_state = tms ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = tms ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
            UPD_DR:  next_state = tms ? SEL_DR : RTI;
            SEL_IR:  next_state = tms ? TLR    : CAP_IR;
            CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
            SH_IR:   next_state = tms ? EX1_IR : SH_IR;
            EX1_IR:  next_state = tms ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = tms ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
            UPD_IR:  next_state = tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase

        dec_tlr_n      = (cur_state != TLR);
        dec_select     = (cur_state inside {SEL_IR, CAP_IR, SH_IR, EX1_IR,
                                            PAU_IR, EX2_IR, UPD_IR});
        dec_enable     = (cur_state == SH_DR) || (cur_state == SH_IR);
        dec_capture_ir = (cur_state == CAP_IR);
        dec_shift_ir   = (cur_state == SH_IR);
        dec_update_ir  = (cur_state == UPD_IR);
        dec_capture_dr = (cur_state == CAP_DR);
        dec_shift_dr   = (cur_state == SH_DR);
        dec_update_dr  = (cur_state == UPD_DR);
        // The rising edge that leaves a capture or shift state is the one
        // the register acts on, so the gated clock is open in both.
        dec_dr_en      = (cur_state == CAP_DR) || (cur_state == SH_DR);
        dec_ir_en      = (cur_state == CAP_IR) || (cur_state == SH_IR);
    end

    // Falling-edge stage: strobes and clock-gate enables only change while
    // tck is low, which keeps them stable across the next rising edge and
    // keeps the gated clocks free of runt pulses.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tlr_n     <= 1'b0;
            select    <= 1'b0;
            enable    <= 1'b0;
            captureIR <= 1'b0;
            shiftIR   <= 1'b0;
            updateIR  <= 1'b0;
            captureDR <= 1'b0;
            shiftDR   <= 1'b0;
            updateDR  <= 1'b0;
            dr_en     <= 1'b0;
            ir_en     <= 1'b0;
        end else begin
            tlr_n     <= dec_tlr_n;
            select    <= dec_select;
            enable    <= dec_enable;
            captureIR <= dec_capture_ir;
            shiftIR   <= dec_shift_ir;
            updateIR  <= dec_update_ir;
            captureDR <= dec_capture_dr;
            shiftDR   <= dec_shift_dr;
            updateDR  <= dec_update_dr;
            dr_en     <= dec_dr_en;
            ir_en     <= dec_ir_en;
        end
    end

    assign state   = cur_state;
    assign clockDR = tck & dr_en;
    assign clockIR = tck & ir_en;

endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller
// Directed bench for tap_controller. TMS is driven while tck is low and all
// outputs are sampled 1 time unit after the falling edge, when both the
// posedge state and the negedge strobes are settled. A behavioural 32-bit
// identification register hangs off clockDR/captureDR to show the strobes
// move real data.
module tb_tap_controller;

    localparam logic [31:0] DEVICE_ID = 32'h1BA0_6477;

    logic       tck  = 1'b0;
    logic       trst = 1'b0;
    logic       tms  = 1'b1;
    logic [3:0] state;
    logic       tlr_n;
    logic       select;
    logic       enable;
    logic       captureIR;
    logic       shiftIR;
    logic       updateIR;
    logic       clockIR;
    logic       captureDR;
    logic       shiftDR;
    logic       updateDR;
    logic       clockDR;

    time         last_rise = 0;
    int          check_cnt = 0;
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;
    int          dr_edges  = 0;
    int          ir_edges  = 0;
    int          cap_edges = 0;
    int          cap_idx   = -1;
    int          glitch_dr = 0;
    int          glitch_ir = 0;
    logic [31:0] id_sr     = '0;
    logic [31:0] out_bits  = '0;

    // Hand-written transition table, indexed by state code.
    logic [3:0] nxt0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                              4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                              4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    // TMS path from Test-Logic-Reset to each state, applied LSB first.
    logic [7:0] path_bits [16] = '{8'b0010_1010, 8'b0000_1010, 8'b0000_0010,
                                   8'b0000_1010, 8'b0000_0110, 8'b0001_1010,
                                   8'b0000_0010, 8'b0000_0010, 8'b0101_0110,
                                   8'b0001_0110, 8'b0000_0110, 8'b0001_0110,
                                   8'b0000_0000, 8'b0011_0110, 8'b0000_0110,
                                   8'b0000_0000};
    int         path_len [16] = '{6, 4, 4, 5, 3, 5, 3, 2, 7, 5, 5, 6, 1, 6, 4, 0};

    tap_controller dut (
        .tck       (tck),
        .trst      (trst),
        .tms       (tms),
        .state     (state),
        .tlr_n     (tlr_n),
        .select    (select),
        .enable    (enable),
        .captureIR (captureIR),
        .shiftIR   (shiftIR),
        .updateIR  (updateIR),
        .clockIR   (clockIR),
        .captureDR (captureDR),
        .shiftDR   (shiftDR),
        .updateDR  (updateDR),
        .clockDR   (clockDR)
    );

    // Test clock, period 10; the rise time is recorded before the gated
    // clocks can react to the edge.
    initial begin
        forever begin
            #5 tck = 1'b1;
            last_rise = $time;
            #5 tck = 1'b0;
        end
    end

    // Identification register model: load on the capture edge, otherwise
    // shift right; out_bits collects what would appear on tdo.
    always @(posedge clockDR) begin
        dr_edges <= dr_edges + 1;
        if (captureDR) begin
            id_sr     <= DEVICE_ID;
            cap_edges <= cap_edges + 1;
            cap_idx   <= dr_edges;
        end else begin
            out_bits <= {id_sr[0], out_bits[31:1]};
            id_sr    <= {1'b0, id_sr[31:1]};
        end
    end

    always @(posedge clockIR) begin
        ir_edges <= ir_edges + 1;
    end

    // Gated clocks may only rise together with tck and only fall with tck
    // (or on reset).
    always @(clockDR) begin
        if (clockDR === 1'b1) begin
            if (tck !== 1'b1 || $time != last_rise) glitch_dr <= glitch_dr + 1;
        end else if (tck !== 1'b0 && trst !== 1'b0) begin
            glitch_dr <= glitch_dr + 1;
        end
    end

    always @(clockIR) begin
        if (clockIR === 1'b1) begin
            if (tck !== 1'b1 || $time != last_rise) glitch_ir <= glitch_ir + 1;
        end else if (tck !== 1'b0 && trst !== 1'b0) begin
            glitch_ir <= glitch_ir + 1;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full tck period: drive TMS in the low phase, pass the rising edge,
    // and stop just after the falling edge.
    task automatic applyStimulus(input logic v);
        tms = v;
        @(posedge tck);
        #1;
        @(negedge tck);
        #1;
    endtask

    task automatic walkPath(input logic [7:0] bits, input int len);
        for (int i = 0; i < len; i++) applyStimulus(bits[i]);
    endtask

    task automatic goReset();
        repeat (5) applyStimulus(1'b1);
    endtask

    int e0;
    int c0;
    int i0;

    initial begin
        $display("[TB] tap_controller directed test");

        // Reset held from time zero.
        @(negedge tck);
        #1;
        @(negedge tck);
        #1;
        checkOutput("reset_state", 32'(state), 32'hF);
        checkOutput("reset_tlr_n", 32'(tlr_n), 32'h0);
        checkOutput("reset_strobes", 32'({select, enable, captureIR, shiftIR, updateIR,
                                          captureDR, shiftDR, updateDR}), 32'h0);
        checkOutput("reset_clocks", 32'({clockDR, clockIR}), 32'h0);

        trst = 1'b1;
        applyStimulus(1'b0);
        checkOutput("release_state", 32'(state), 32'hC);
        checkOutput("release_tlr_n", 32'(tlr_n), 32'h1);

        // Reset in the middle of Shift-DR.
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("shdr_state", 32'(state), 32'h2);
        checkOutput("shdr_shift_enable", 32'({shiftDR, enable}), 32'h3);
        trst = 1'b0;
        #1;
        checkOutput("midreset_state", 32'(state), 32'hF);
        checkOutput("midreset_tlr_n", 32'(tlr_n), 32'h0);
        checkOutput("midreset_strobes", 32'({select, enable, captureDR, shiftDR, updateDR}),
                    32'h0);
        checkOutput("midreset_clockDR", 32'(clockDR), 32'h0);
        e0 = dr_edges;
        @(posedge tck);
        @(negedge tck);
        @(posedge tck);
        @(negedge tck);
        #1;
        checkOutput("midreset_no_clockDR", 32'(dr_edges), 32'(e0));
        trst = 1'b1;
        applyStimulus(1'b0);
        checkOutput("rerelease_state", 32'(state), 32'hC);

        // Reachability, convergence and the full transition table.
        for (int s = 0; s < 16; s++) begin
            goReset();
            walkPath(path_bits[s], path_len[s]);
            checkOutput($sformatf("reach_%0h", s), 32'(state), 32'(s));
            goReset();
            checkOutput($sformatf("converge_from_%0h", s), 32'(state), 32'hF);
            walkPath(path_bits[s], path_len[s]);
            applyStimulus(1'b0);
            checkOutput($sformatf("next_%0h_tms0", s), 32'(state), 32'(nxt0[s]));
            goReset();
            walkPath(path_bits[s], path_len[s]);
            applyStimulus(1'b1);
            checkOutput($sformatf("next_%0h_tms1", s), 32'(state), 32'(nxt1[s]));
        end
        goReset();
        applyStimulus(1'b0);

        // IDCODE read: capture edge + 32 shift edges.
        e0 = dr_edges;
        c0 = cap_edges;
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("capdr_strobe", 32'({captureDR, enable, select}), 32'h4);
        applyStimulus(1'b0);
        checkOutput("shdr_strobe", 32'({captureDR, shiftDR, enable}), 32'h3);
        repeat (31) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("idcode_ex1_state", 32'(state), 32'h1);
        checkOutput("idcode_clockDR_edges", 32'(dr_edges - e0), 32'd33);
        checkOutput("idcode_capture_count", 32'(cap_edges - c0), 32'd1);
        checkOutput("idcode_capture_first", 32'(cap_idx), 32'(e0));
        checkOutput("idcode_tdo_bits", out_bits, DEVICE_ID);
        checkOutput("idcode_bit0", 32'(out_bits[0]), 32'h1);
        checkOutput("ex1dr_enable", 32'(enable), 32'h0);
        applyStimulus(1'b1);
        checkOutput("upddr_state", 32'(state), 32'h5);
        checkOutput("upddr_strobe", 32'(updateDR), 32'h1);
        applyStimulus(1'b0);
        checkOutput("upddr_done_state", 32'(state), 32'hC);
        checkOutput("upddr_done_strobe", 32'(updateDR), 32'h0);

        // Pause hold: 8 shifts, 20 cycles paused, then the remaining 24.
        e0 = dr_edges;
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        repeat (7) applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("pause_state", 32'(state), 32'h3);
        checkOutput("pause_edges_before", 32'(dr_edges - e0), 32'd9);
        i0 = dr_edges;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("pause_enable_%0d", k), 32'({enable, shiftDR}), 32'h0);
        end
        applyStimulus(1'b1);
        checkOutput("ex2dr_state", 32'(state), 32'h0);
        applyStimulus(1'b0);
        checkOutput("pause_no_clockDR", 32'(dr_edges), 32'(i0));
        checkOutput("resume_state", 32'(state), 32'h2);
        repeat (23) applyStimulus(1'b0);
        applyStimulus(1'b1);
        checkOutput("pause_total_edges", 32'(dr_edges - e0), 32'd33);
        checkOutput("pause_data_intact", out_bits, DEVICE_ID);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        checkOutput("pause_back_rti", 32'(state), 32'hC);

        // IR path.
        e0 = dr_edges;
        i0 = ir_edges;
        applyStimulus(1'b1);
        checkOutput("ir_seldr_select", 32'(select), 32'h0);
        applyStimulus(1'b1);
        checkOutput("ir_selir", 32'({state, select}), 32'h9);
        applyStimulus(1'b0);
        checkOutput("ir_capir", 32'({state, select, captureIR}), 32'h3B);
        applyStimulus(1'b0);
        checkOutput("ir_shir", 32'({state, select, shiftIR, enable}), 32'h57);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("ir_shift_%0d", k), 32'({select, shiftIR, enable}), 32'h7);
        end
        applyStimulus(1'b1);
        checkOutput("ir_ex1ir", 32'({state, select, enable}), 32'h26);
        checkOutput("ir_clockIR_edges", 32'(ir_edges - i0), 32'd5);
        checkOutput("ir_no_clockDR", 32'(dr_edges), 32'(e0));
        tms = 1'b1;
        @(posedge tck);
        #1;
        checkOutput("updir_state_early", 32'(state), 32'hD);
        checkOutput("updir_strobe_latency", 32'(updateIR), 32'h0);
        @(negedge tck);
        #1;
        checkOutput("updir_strobe", 32'({updateIR, select}), 32'h3);
        applyStimulus(1'b0);
        checkOutput("updir_done", 32'({state, updateIR, select}), 32'h30);

        checkOutput("glitch_clockDR", 32'(glitch_dr), 32'h0);
        checkOutput("glitch_clockIR", 32'(glitch_ir), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1 TAP controller that decodes TMS on TCK into the 16-state TAP state machine and produces the register control strobes. It sits directly upstream of every data register in the drop-in JTAG block, including the device identification register, and the instruction register. Every DR consumes `clockDR`/`captureDR`, samples `tdi` on `clockDR` rising edges, and shifts toward `tdo`.

## Interface
- No parameters.
- `tck` input 1: JTAG test clock; the only clock.
- `trst` input 1: asynchronous, active-low test reset.
- `tms` input 1: test mode select, sampled on `tck` rising edge.
- `state` output 4: current TAP state, standard 1149.1 encoding; debug/observation.
- `tlr_n` output 1: active-low test-logic reset to the instruction decoder; low while in Test-Logic-Reset.
- `select` output 1: 1 = IR path (for the TDO mux), 0 = DR path.
- `enable` output 1: TDO output-driver enable; high in Shift-IR/Shift-DR.
- `captureIR`, `shiftIR`, `updateIR` output 1 each: IR control levels.
- `clockIR` output 1: gated IR shift/capture clock.
- `captureDR`, `shiftDR`, `updateDR` output 1 each: DR control levels.
- `clockDR` output 1: gated DR shift/capture clock.

## Operation
- State encoding (hex), fixed:
  - TLR=F, RTI=C.
  - SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5.
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D.
- Transitions on `tck` rising edge, written as next state for TMS=0 / TMS=1:
  - TLR→RTI/TLR; RTI→RTI/SelDR.
  - SelDR→CapDR/SelIR; CapDR→ShDR/Ex1DR; ShDR→ShDR/Ex1DR.
  - Ex1DR→PauDR/UpdDR; PauDR→PauDR/Ex2DR; Ex2DR→ShDR/UpdDR; UpdDR→RTI/SelDR.
  - SelIR→CapIR/TLR; CapIR→ShIR/Ex1IR; ShIR→ShIR/Ex1IR.
  - Ex1IR→PauIR/UpdIR; PauIR→PauIR/Ex2IR; Ex2IR→ShIR/UpdIR; UpdIR→RTI/SelDR.
- Five consecutive TMS=1 rising edges reach TLR from any state.
- `state` is the posedge state register itself, with no extra delay.
- Control outputs are decoded from `state` and registered on the `tck` falling edge. They are therefore stable across the next rising edge:
  - `captureDR` = CapDR; `shiftDR` = ShDR; `updateDR` = UpdDR.
  - IR strobes follow the same pattern.
  - `enable` = ShDR|ShIR.
  - `select` = state in the IR column (SelIR through UpdIR).
  - `tlr_n` = !(TLR).
- Clock gating:
  - `clockDR` = `tck` AND `dr_en`, where `dr_en` is a falling-edge register set when state ∈ {CapDR, ShDR}.
  - `clockIR` is built the same way, with state ∈ {CapIR, ShIR}.
  - The enable changes only while `tck` is low, so the gated clocks are glitch-free.
- The only combinational logic from `tck` to outputs is the two clock AND gates.

## Timing
- `trst` low, asynchronous and immediate:
  - state=TLR;
  - all falling-edge registers cleared, with `tlr_n`=0;
  - `clockDR`=`clockIR`=0.
- `trst` deassertion is sampled at the next rising edge. TMS is honoured from that first edge.
- Reset mid-shift (e.g. in ShDR): all strobes drop immediately and no further `clockDR` edges occur.
- Capture: the rising edge that leaves CapDR is the single capture edge. `captureDR`=1 on that edge.
- Shift: one `clockDR` rising edge per rising edge taken from ShDR, including the edge that exits to Ex1DR.
- Update: `updateDR` rises on the falling edge in UpdDR and falls on the following falling edge, giving one tck period. Downstream latches load on its rising edge.
- Pause/Exit states: no `clockDR` edges and `enable`=0. DR contents therefore hold indefinitely in PauDR.
- Latency from TMS to strobe: TMS sampled at rising edge N moves `state` at edge N. The matching strobe asserts at the falling edge half a period later.

## Test plan
- Reset and recovery:
  - Assert `trst`=0 from ShDR → immediately state=F, `tlr_n`=0, all strobes 0, `clockDR` low.
  - Release `trst`, then TMS=0 → state=C, `tlr_n`=1 after the next falling edge.
- TLR convergence:
  - From each of the 16 states, apply TMS=1 for five edges → state=F.
  - Verify every transition in the table with TMS=0/1 pairs.
- IDCODE read:
  - From RTI, apply TMS=1,0,0 (capture edge), then 31×TMS=0 and 1×TMS=1.
  - Exactly 33 `clockDR` rising edges, first with `captureDR`=1.
  - Attached ID register yields DEVICE_ID LSB-first on `tdo`, bit0=1.
- Pause hold:
  - Shift 8 bits, go Ex1DR→PauDR for 20 cycles, then Ex2DR→ShDR.
  - No `clockDR` edges and `enable`=0 during pause; shifting resumes with the data intact.
- IR path:
  - From RTI, apply TMS=1,1,0,0 (capture), then 3×0, 1×1 (exit), then 1 (update).
  - `select`=1 throughout, 5 `clockIR` edges.
  - `updateIR` high for one tck period starting at the UpdIR falling edge; state=D then C with TMS=0.
- Glitch check: `clockDR`/`clockIR` never pulse while `tck` is high except as a full-width copy of the `tck` high phase.
